// File: rtl/counter_pkg.sv
// Shared encodings for the LED counter mode controller: counting modes,
// handover FSM states and the mode bus width.
package counter_pkg;

   localparam int MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      MODE_UP      = 2'd0,
      MODE_DOWN    = 2'd1,
      MODE_RING    = 2'd2,
      MODE_JOHNSON = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HOLD  = 2'd1,
      ST_CLEAR = 2'd2
   } state_e;

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchronizer followed by a stability counter for the 2-bit mode
// switches; the output follows the pins only after DEBOUNCE steady cycles.
module sw_debounce
   import counter_pkg::*;
#(
   parameter int DEBOUNCE = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [MODE_W-1:0] sw_i,
   output logic [MODE_W-1:0] sw_db_o
);

   localparam int CW = $clog2(DEBOUNCE + 1);

   logic [MODE_W-1:0] sync1_q;
   logic [MODE_W-1:0] sync2_q;
   logic [MODE_W-1:0] db_q, db_d;
   logic [CW-1:0]     cnt_q, cnt_d;

   // cnt_q holds the number of edges sync2_q has stayed put since it last
   // moved, so sync2_q has been steady for cnt_q+1 cycles when it is tested.
   always_comb begin
      db_d  = db_q;
      cnt_d = cnt_q;
      if (sync2_q == db_q) begin
         cnt_d = '0;
      end else if (cnt_q == CW'(DEBOUNCE - 1)) begin
         db_d  = sync2_q;
         cnt_d = '0;
      end else if (sync1_q != sync2_q) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         db_q    <= '0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sw_i;
         sync2_q <= sync1_q;
         db_q    <= db_d;
         cnt_q   <= cnt_d;
      end
   end

   assign sw_db_o = db_q;

endmodule

// File: rtl/counter_mode_sched.sv
// Mode controller for the LED counter: prescaled count tick, manual or
// auto-cycled mode selection, and a hold-then-clear handover on each change.
module counter_mode_sched
   import counter_pkg::*;
#(
   parameter int DIV      = 10,
   parameter int DEBOUNCE = 4,
   parameter int DWELL    = 16
) (
   input  logic              clk,
   input  logic              btnC,
   input  logic [MODE_W-1:0] sw,
   input  logic              auto_en,
   output logic [MODE_W-1:0] mode,
   output logic              cnt_tick,
   output logic              cnt_clr,
   output logic              busy
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

   state_e            state_q, state_d;
   logic [PW-1:0]     pcnt_q, pcnt_d;
   logic [DW-1:0]     dwell_q, dwell_d;
   logic [MODE_W-1:0] mode_q, mode_d;
   logic [MODE_W-1:0] pend_q, pend_d;
   logic              clr_q, clr_d;
   logic [MODE_W-1:0] swDb;
   logic              tick;
   logic              req;
   logic              lastDwell;
   logic [MODE_W-1:0] nextMode;

   sw_debounce #(
      .DEBOUNCE (DEBOUNCE)
   ) u_sw_debounce (
      .clk     (clk),
      .rst     (btnC),
      .sw_i    (sw),
      .sw_db_o (swDb)
   );

   // In RUN a request may coincide with a tick; the tick is still issued and
   // the handover starts on the following edge. HOLD leaves pcnt untouched.
   always_comb begin
      state_d   = state_q;
      pcnt_d    = pcnt_q;
      dwell_d   = dwell_q;
      mode_d    = mode_q;
      pend_d    = pend_q;
      clr_d     = 1'b0;
      tick      = 1'b0;
      req       = 1'b0;
      nextMode  = swDb;
      lastDwell = (dwell_q == DW'(DWELL - 1));
      case (state_q)
         ST_RUN: begin
            tick = (pcnt_q == PW'(DIV - 1));
            if (tick) begin
               pcnt_d  = '0;
               dwell_d = lastDwell ? '0 : dwell_q + DW'(1);
            end else begin
               pcnt_d  = pcnt_q + PW'(1);
            end
            if (auto_en) begin
               req      = tick && lastDwell;
               nextMode = mode_q + MODE_W'(1);
            end else begin
               req      = (swDb != mode_q);
            end
            if (req) begin
               pend_d  = nextMode;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            clr_d   = 1'b1;
            state_d = ST_CLEAR;
         end
         ST_CLEAR: begin
            mode_d  = pend_q;
            pcnt_d  = '0;
            dwell_d = '0;
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk or posedge btnC) begin
      if (btnC) begin
         state_q <= ST_RUN;
         pcnt_q  <= '0;
         dwell_q <= '0;
         mode_q  <= MODE_UP;
         pend_q  <= MODE_UP;
         clr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pcnt_q  <= pcnt_d;
         dwell_q <= dwell_d;
         mode_q  <= mode_d;
         pend_q  <= pend_d;
         clr_q   <= clr_d;
      end
   end

   assign mode     = mode_q;
   assign cnt_tick = tick;
   assign cnt_clr  = clr_q;
   assign busy     = (state_q != ST_RUN);

endmodule

// File: tb/tb_counter_mode_sched.sv
// Randomized and directed bench for counter_mode_sched, compared cycle by
// cycle against a behavioural model of the mode controller.
module tb_counter_mode_sched;

   localparam int DIV      = 10;
   localparam int DEBOUNCE = 4;
   localparam int DWELL    = 16;

   logic       clk;
   logic       btnC;
   logic [1:0] sw;
   logic       auto_en;
   logic [1:0] mode;
   logic       cnt_tick;
   logic       cnt_clr;
   logic       busy;

   int assertCount = 0;
   int failCount   = 0;

   // Model state: changeLeft counts the handover cycles still to come
   // (2 = holding, 1 = clearing, 0 = running); runIdx counts running cycles
   // since the current mode took effect.
   int mMode;
   int changeLeft;
   int runIdx;
   int ticksInMode;
   int pendMode;
   int dbVal;
   int syncRun;
   int hist[$];

   counter_mode_sched #(
      .DIV      (DIV),
      .DEBOUNCE (DEBOUNCE),
      .DWELL    (DWELL)
   ) dut (
      .clk      (clk),
      .btnC     (btnC),
      .sw       (sw),
      .auto_en  (auto_en),
      .mode     (mode),
      .cnt_tick (cnt_tick),
      .cnt_clr  (cnt_clr),
      .busy     (busy)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      assertCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic bit expTick();
      return (changeLeft == 0) && ((runIdx % DIV) == DIV - 1);
   endfunction

   task automatic modelReset();
      mMode       = 0;
      changeLeft  = 0;
      runIdx      = 0;
      ticksInMode = 0;
      pendMode    = 0;
      dbVal       = 0;
      syncRun     = 1;
      hist.delete();
      hist.push_back(0);
      hist.push_back(0);
   endtask

   // Advances the model across one rising edge with the inputs seen there.
   task automatic modelEdge(input int swIn, input bit autoIn);
      bit tick;
      bit req;
      int nxt;
      int curSync;
      int newSync;
      tick = expTick();
      req  = 1'b0;
      nxt  = autoIn ? (mMode + 1) % 4 : dbVal;
      if (changeLeft == 0)
         req = autoIn ? (tick && (ticksInMode % DWELL) == DWELL - 1) : (dbVal != mMode);
      case (changeLeft)
         0: begin
            runIdx++;
            if (tick) ticksInMode++;
            if (req) begin
               changeLeft = 2;
               pendMode   = nxt;
            end
         end
         2: changeLeft = 1;
         default: begin
            changeLeft  = 0;
            mMode       = pendMode;
            runIdx      = 0;
            ticksInMode = 0;
         end
      endcase
      curSync = hist[0];
      newSync = hist[1];
      if (syncRun >= DEBOUNCE && curSync != dbVal) dbVal = curSync;
      syncRun = (newSync == curSync) ? ((syncRun < 1000) ? syncRun + 1 : syncRun) : 1;
      void'(hist.pop_front());
      hist.push_back(swIn);
   endtask

   // Drives one cycle of inputs from just after a falling edge and checks the
   // outputs shortly after the following rising edge.
   task automatic applyStimulus(input logic [1:0] swIn, input logic autoIn);
      sw      = swIn;
      auto_en = autoIn;
      @(posedge clk);
      modelEdge(int'(swIn), autoIn);
      #1;
      checkOutput("mode", 8'(mode), 8'(mMode));
      checkOutput("cnt_tick", 8'(cnt_tick), 8'(expTick()));
      checkOutput("cnt_clr", 8'(cnt_clr), 8'(changeLeft == 1));
      checkOutput("busy", 8'(busy), 8'(changeLeft != 0));
      @(negedge clk);
   endtask

   initial begin
      logic [1:0] swVal;
      btnC    = 1'b1;
      sw      = 2'd0;
      auto_en = 1'b0;
      modelReset();
      repeat (3) @(negedge clk);
      checkOutput("rst_mode", 8'(mode), 8'd0);
      checkOutput("rst_tick", 8'(cnt_tick), 8'd0);
      checkOutput("rst_clr", 8'(cnt_clr), 8'd0);
      checkOutput("rst_busy", 8'(busy), 8'd0);
      btnC = 1'b0;

      $display("[TB] idle counting in UP");
      repeat (30) applyStimulus(2'd0, 1'b0);

      $display("[TB] short switch glitch");
      repeat (3) applyStimulus(2'd1, 1'b0);
      repeat (20) applyStimulus(2'd0, 1'b0);
      checkOutput("glitch_mode", 8'(mode), 8'd0);

      $display("[TB] manual change to RING");
      repeat (30) applyStimulus(2'd2, 1'b0);
      checkOutput("manual_mode", 8'(mode), 8'd2);

      $display("[TB] random manual switching");
      swVal = 2'd2;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 7) == 0) swVal = 2'($urandom_range(0, 3));
         applyStimulus(swVal, 1'b0);
      end

      $display("[TB] auto cycling with switch noise");
      for (int i = 0; i < 700; i++) begin
         if ($urandom_range(0, 5) == 0) swVal = 2'($urandom_range(0, 3));
         applyStimulus(swVal, 1'b1);
      end

      $display("[TB] reset during clear");
      for (int i = 0; i < 400 && changeLeft != 1; i++) applyStimulus(2'd0, 1'b1);
      checkOutput("clear_reached", 8'(changeLeft == 1), 8'd1);
      #3 btnC = 1'b1;
      #1;
      checkOutput("abort_mode", 8'(mode), 8'd0);
      checkOutput("abort_tick", 8'(cnt_tick), 8'd0);
      checkOutput("abort_clr", 8'(cnt_clr), 8'd0);
      checkOutput("abort_busy", 8'(busy), 8'd0);
      #2 btnC = 1'b0;
      modelReset();
      repeat (20) applyStimulus(2'd0, 1'b0);

      $display("[TB] switch moved while busy, then auto off");
      for (int i = 0; i < 400 && changeLeft != 2; i++) applyStimulus(2'd0, 1'b1);
      checkOutput("hold_reached", 8'(changeLeft == 2), 8'd1);
      repeat (40) applyStimulus(2'd3, 1'b0);
      checkOutput("final_mode", 8'(mode), 8'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
